// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline hazard/stall control bundle between datapath and controller
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_reg_write, ex_branch_taken, mem_req, mem_ack,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, mem_err, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_reg_write, ex_branch_taken, mem_req, mem_ack,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, mem_err, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall, branch flush and memory-wait freeze sequencer
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam int WC_W = $clog2(WAIT_LIMIT + 1);

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic            err_q, err_d;

    logic load_use;
    logic mem_wait;
    logic freeze;

    assign load_use = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign mem_wait = bus.mem_req && !bus.mem_ack;

    // MEM_REQ is ignored on the ACK cycle, so only RUN can start a new freeze.
    assign freeze = (state_q == HALT) ||
                    ((state_q == MEM_WAIT) && !bus.mem_ack) ||
                    ((state_q == RUN) && mem_wait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    wait_d  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WC_W'(WAIT_LIMIT - 1)) begin
                    state_d = HALT;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_write   = 1'b1;
        bus.id_ex_flush   = 1'b0;
        bus.ex_mem_write  = 1'b1;
        bus.mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_write   = 1'b0;
            bus.ex_mem_write  = 1'b0;
            bus.id_ex_flush   = 1'b1;
            bus.mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_write   = 1'b0;
            bus.ex_mem_write  = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            // Decode instruction is discarded, so a coincident load-use is moot.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    assign bus.state   = state_q;
    assign bus.mem_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q != HALT) && !bus.pc_write && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (bus.if_id_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule
